// File: rtl/arm_ctrl_pkg.sv
// rtl/arm_ctrl_pkg.sv - shared encodings for the multicycle ARM control path
//
// Purpose: state encodings, opcode constants, ALU operand/op codes, the
// opcode class enum and the bundled control-strobe struct. This package is
// shared by the control FSM, the opcode decoder and the ALU control block.
// Ports: none (package).
package arm_ctrl_pkg;

  // FSM state encodings (4-bit, visible on the state output)
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXEC_R = 4'd2;
  localparam logic [3:0] S_WB_R   = 4'd3;
  localparam logic [3:0] S_ADDR   = 4'd4;
  localparam logic [3:0] S_MEM_RD = 4'd5;
  localparam logic [3:0] S_WB_MEM = 4'd6;
  localparam logic [3:0] S_MEM_WR = 4'd7;
  localparam logic [3:0] S_CBZ    = 4'd8;
  localparam logic [3:0] S_BR     = 4'd9;

  // Full 11-bit opcodes
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  // CBZ and B carry immediate bits in the low opcode field, so only the
  // fixed prefix is matched: CBZ = opcode[10:3], B = opcode[10:5].
  localparam logic [7:0] OP_CBZ_PREFIX = 8'b10110100;
  localparam logic [5:0] OP_B_PREFIX   = 6'b000101;

  // ALU operation select
  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_PASS_B = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] SRC_B_REG      = 2'b00;
  localparam logic [1:0] SRC_B_FOUR     = 2'b01;
  localparam logic [1:0] SRC_B_SEXT     = 2'b10;
  localparam logic [1:0] SRC_B_SEXT_SH2 = 2'b11;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_RTYPE   = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_CBZ     = 3'd4,
    CLS_B       = 3'd5
  } op_class_t;

  // Every state-decoded control output, so a whole set can be cleared at once
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic       pc_source;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/opcode_decode.sv
// rtl/opcode_decode.sv - classifies an 11-bit ARM opcode
//
// Purpose: maps instruction[31:21] onto an instruction class and derives
// reg2loc (second register read port takes Rt for STUR/CBZ).
// Ports:
//   opcode_i   in  11  instruction[31:21]
//   op_class_o out  3  decoded class (CLS_ILLEGAL when unrecognised)
//   reg2loc_o  out  1  1 for STUR and CBZ
module opcode_decode
  import arm_ctrl_pkg::*;
(
  input  logic [10:0] opcode_i,
  output op_class_t   op_class_o,
  output logic        reg2loc_o
);

  always_comb begin
    op_class_o = CLS_ILLEGAL;
    if ((opcode_i == OP_ADD) || (opcode_i == OP_SUB) ||
        (opcode_i == OP_AND) || (opcode_i == OP_ORR)) begin
      op_class_o = CLS_RTYPE;
    end else if (opcode_i == OP_LDUR) begin
      op_class_o = CLS_LOAD;
    end else if (opcode_i == OP_STUR) begin
      op_class_o = CLS_STORE;
    end else if (opcode_i[10:3] == OP_CBZ_PREFIX) begin
      op_class_o = CLS_CBZ;
    end else if (opcode_i[10:5] == OP_B_PREFIX) begin
      op_class_o = CLS_B;
    end
  end

  assign reg2loc_o = (op_class_o == CLS_STORE) || (op_class_o == CLS_CBZ);

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle ARM datapath control FSM
//
// Purpose: Moore-style control FSM sequencing FETCH/DECODE and the per-class
// execution states; all strobes come from the current state (FETCH and
// MEM_WR also qualify with mem_ready), reg2loc comes straight from the decoder.
// Ports:
//   clk           in   1  rising-edge clock
//   reset         in   1  asynchronous active-high, forces FETCH
//   opcode        in  11  instruction[31:21] from the IR
//   mem_ready     in   1  shared memory access completes this cycle
//   pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
//   reg_write, mem_to_reg, reg2loc, alu_src_a, pc_source
//                 out  1  datapath strobes / mux selects
//   alu_src_b     out  2  00 reg, 01 const 4, 10 sign-ext, 11 sign-ext<<2
//   alu_op        out  2  00 add, 01 pass-B, 10 funct
//   state         out  4  current state encoding
//   instr_done    out  1  pulse in the final cycle of a legal instruction
//   illegal       out  1  pulse in the FETCH cycle after an illegal decode
module multicycle_control
  import arm_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] opcode,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        ir_write,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        reg2loc,
  output logic        alu_src_a,
  output logic        pc_source,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [3:0]  state,
  output logic        instr_done,
  output logic        illegal
);

  logic [3:0] state_q, state_d;
  // Load/store direction is captured at DECODE so a later opcode change
  // cannot redirect ADDR to the other memory state.
  logic       is_store_q, is_store_d;
  logic       illegal_q, illegal_d;

  op_class_t  op_class;
  logic       dec_reg2loc;
  ctrl_t      ctrl;

  opcode_decode u_opcode_decode (
    .opcode_i   (opcode),
    .op_class_o (op_class),
    .reg2loc_o  (dec_reg2loc)
  );

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    illegal_d  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        is_store_d = (op_class == CLS_STORE);
        case (op_class)
          CLS_RTYPE: state_d = S_EXEC_R;
          CLS_LOAD:  state_d = S_ADDR;
          CLS_STORE: state_d = S_ADDR;
          CLS_CBZ:   state_d = S_CBZ;
          CLS_B:     state_d = S_BR;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC_R: state_d = S_WB_R;
      S_WB_R:   state_d = S_FETCH;
      S_ADDR:   state_d = is_store_q ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_WB_MEM: state_d = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready) state_d = S_FETCH;
      end
      S_CBZ:    state_d = S_FETCH;
      S_BR:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      is_store_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      illegal_q  <= illegal_d;
    end
  end

  // Output decode; anything not set in a state stays 0
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Precompute PC + (sign-ext << 2) for a possible branch
        ctrl.alu_src_b = SRC_B_SEXT_SH2;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      S_WB_R: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_SEXT;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_CBZ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_REG;
        ctrl.alu_op        = ALU_OP_PASS_B;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 1'b1;
        ctrl.instr_done    = 1'b1;
      end
      S_BR: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
    // Reset silences every strobe immediately, not just at the next edge
    if (reset) ctrl = '0;
  end

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign ir_write      = ctrl.ir_write;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign reg_write     = ctrl.reg_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign alu_src_a     = ctrl.alu_src_a;
  assign pc_source     = ctrl.pc_source;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign instr_done    = ctrl.instr_done;
  assign reg2loc       = dec_reg2loc;
  assign state         = state_q;
  assign illegal       = illegal_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; forces FETCH.
REQ-003 SHALL have port: opcode  input  11  instruction[31:21] from the instruction register.
REQ-004 SHALL have port: mem_ready  input  1  shared memory access complete this cycle.
REQ-005 SHALL have outputs, each 1 bit unless stated:
- pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write
- reg_write, mem_to_reg, reg2loc, alu_src_a, pc_source
- alu_src_b (2: 00 reg, 01 const 4, 10 sign-ext, 11 sign-ext<<2)
- alu_op (2: 00 add, 01 pass-B, 10 funct)
- state (4)
- instr_done (1-cycle pulse)
- illegal (1-cycle pulse)

Function
REQ-006 SHALL be a Moore FSM with outputs decoded from state only; reg2loc is the exception (REQ-016).
REQ-007 State encodings SHALL be:
- FETCH=0, DECODE=1, EXEC_R=2, WB_R=3, ADDR=4
- MEM_RD=5, WB_MEM=6, MEM_WR=7, CBZ=8, BR=9
REQ-008 FETCH SHALL drive mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=0.
- ir_write=pc_write=mem_ready.
- Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-009 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=00 to latch the branch target.
- Next state by opcode: ADD/SUB/AND/ORR -> EXEC_R; LDUR/STUR -> ADDR; CBZ -> CBZ; B -> BR.
- Any other opcode -> FETCH with illegal=1 for one cycle.
REQ-010 Opcode matching SHALL be:
- ADD=10001011000, SUB=11001011000, AND=10001010000, ORR=10101010000
- LDUR=11111000010, STUR=11111000000
- CBZ=10110100xxx, B=000101xxxxx
REQ-011 EXEC_R SHALL drive alu_src_a=1, alu_src_b=00, alu_op=10, then go to WB_R.
REQ-012 WB_R SHALL drive reg_write=1, mem_to_reg=0, then go to FETCH.
REQ-013 ADDR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00, then go to MEM_RD (LDUR) or MEM_WR (STUR).
REQ-014 MEM_RD and MEM_WR SHALL hold while mem_ready=0.
- MEM_RD: mem_read=1, i_or_d=1; on mem_ready go to WB_MEM.
- MEM_WR: mem_write=1, i_or_d=1; on mem_ready go to FETCH.
- WB_MEM: reg_write=1, mem_to_reg=1, then go to FETCH.
REQ-015 Branch states SHALL go to FETCH after one cycle:
- CBZ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=1.
- BR: pc_write=1, pc_source=1.
REQ-016 reg2loc SHALL equal 1 whenever opcode decodes as STUR or CBZ, in every state, combinationally.
REQ-017 instr_done SHALL pulse high in the final cycle of every legal instruction (WB_R, WB_MEM, MEM_WR with mem_ready, CBZ, BR).
REQ-018 With mem_ready tied high, instruction latency in cycles SHALL be R=4, LDUR=5, STUR=4, CBZ=3, B=3.
REQ-019 Every strobe not listed for a state SHALL be 0; mem_read and mem_write SHALL never be high together.
REQ-020 An opcode change while in a state beyond DECODE SHALL NOT alter the state path already chosen.

Reset
REQ-021 Reset assertion SHALL asynchronously force state=FETCH and, while held, force all strobes, instr_done and illegal to 0.
REQ-022 Reset mid-instruction SHALL abort it with no write strobe asserted; the first cycle after release SHALL be FETCH.

Structure
REQ-023 Opcode constants, state encodings, alu_op and alu_src_b codes SHALL live in shared package arm_ctrl_pkg, reused by control_unit and alu_control.
REQ-024 Opcode classification SHALL be one sub-module, opcode_decode (opcode -> class, reg2loc); the FSM stays in multicycle_control.

Verification
REQ-025 Bench SHALL cover these directed scenarios:
- ADD 10001011000, mem_ready=1 -> states 0,1,2,3,0; reg_write only in state 3; instr_done at cycle 4.
- LDUR, mem_ready low 3 cycles in MEM_RD -> stays in 5 for 4 cycles; then 6 with mem_to_reg=1; latency 8.
- STUR 11111000000 -> reg2loc=1 from cycle 1; mem_write only in state 7; no reg_write.
- CBZ 10110100101 -> states 0,1,8; pc_write_cond=1, pc_source=1 in state 8.
- Opcode 11111111111 -> DECODE returns to FETCH, illegal=1 one cycle, instr_done=0.
- Reset asserted in MEM_WR -> state=0 and mem_write=0 immediately, before the next clock edge.
